// File: rtl/sop_sweep_ctrl_pkg.sv
// rtl/sop_sweep_ctrl_pkg.sv - shared states, widths and golden truth table for the SOP sweep
package sop_sweep_ctrl_pkg;

  localparam int VEC_W = 4;
  localparam int ERR_W = 5;
  localparam int CNT_W = 4;

  localparam logic [VEC_W-1:0] VEC_LAST = '1;

  // Bit i is y = a&~b | c&~d for vector i = {a,b,c,d}
  localparam logic [15:0] SOP_TRUTH_TABLE = 16'h4F44;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/sop_sweep_ctrl_settle_timer.sv
// rtl/sop_sweep_ctrl_settle_timer.sv - up/down settle counter with load, clear and terminal count
module sweep_settle_timer
  import sop_sweep_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         down_i,
  input  logic [W-1:0] term_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear beats load beats count
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = down_i ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_val_i);

endmodule

// File: rtl/sop_sweep_ctrl.sv
// rtl/sop_sweep_ctrl.sv - exhaustive 16-vector sweep of the SOP datapath with golden compare
module sop_sweep_ctrl
  import sop_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] TRUTH_TABLE   = SOP_TRUTH_TABLE,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             y_in,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);

  sweep_state_e     state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [VEC_W-1:0] ffv_q, ffv_d;
  logic             ffval_q, ffval_d;
  logic             pass_q, pass_d;
  logic             mismatch;
  logic             settle_tc;
  logic             settle_clr;
  logic             settle_en;

  assign mismatch   = y_in ^ TRUTH_TABLE[vec_q];
  assign settle_en  = (state_q == ST_SETTLE);
  // Counter sits at zero outside SETTLE so every vector starts a fresh wait
  assign settle_clr = (state_q != ST_SETTLE) | settle_tc | abort;

  sweep_settle_timer #(
    .W (CNT_W)
  ) u_settle (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (settle_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (settle_en),
    .down_i     (1'b0),
    .term_val_i (SETTLE_TC),
    .tc_o       (settle_tc)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    pass_d  = pass_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SETTLE;
          vec_d   = '0;
          err_d   = '0;
          ffv_d   = '0;
          ffval_d = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (settle_tc) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!ffval_q) begin
            ffv_d   = vec_q;
            ffval_d = 1'b1;
          end
        end
        if ((vec_q == VEC_LAST) || (mismatch && STOP_ON_FAIL)) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything but leaves the error record for debug
    if (abort) begin
      state_d = ST_IDLE;
      vec_d   = '0;
      pass_d  = 1'b0;
      err_d   = err_q;
      ffv_d   = ffv_q;
      ffval_d = ffval_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
      pass_q  <= pass_d;
    end
  end

  assign a                = vec_q[3];
  assign b                = vec_q[2];
  assign c                = vec_q[1];
  assign d                = vec_q[0];
  assign busy             = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done             = (state_q == ST_DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// tb/tb_sop_sweep_ctrl.sv - scoreboard bench for sop_sweep_ctrl with directed sweeps
module tb_sop_sweep_ctrl;

  typedef struct {
    int vec;
    int err;
    int ffv;
    int ffval;
    int pass;
    int busy;
    int done;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, y_in;
  logic       a, b, c, d, busy, done, pass, ffval;
  logic [4:0] err;
  logic [3:0] ffv;
  logic       start_s = 1'b0, abort_s = 1'b0, y_s;
  logic       a_s, b_s, c_s, d_s, busy_s, done_s, pass_s, ffval_s;
  logic [4:0] err_s;
  logic [3:0] ffv_s;

  int  fault_mode = 0;
  int  checks = 0;
  int  errors = 0;
  bit  probe_req = 1'b0;
  time last_start_t = 0;
  time last_start_s_t = 0;

  exp_t done_q[$];
  exp_t sof_q[$];
  exp_t probe_q[$];
  int   vec_exp_q[$];

  always #5 clk = ~clk;

  // Golden datapath with optional fault injection
  always_comb begin
    y_in = (a & ~b) | (c & ~d);
    if (fault_mode == 1 && {a, b, c, d} == 4'd9) y_in = 1'b0;
    else if (fault_mode == 2) y_in = 1'b1;
  end
  assign y_s = 1'b1;

  sop_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y_in),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .pass(pass),
    .err_count(err), .first_fail_vec(ffv), .first_fail_valid(ffval)
  );

  sop_sweep_ctrl #(.STOP_ON_FAIL(1'b1)) dut_sof (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .y_in(y_s),
    .a(a_s), .b(b_s), .c(c_s), .d(d_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .first_fail_vec(ffv_s), .first_fail_valid(ffval_s)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(int v, int e, int fv, int fval, int p, int bs, int dn, int lat);
    exp_t r;
    r.vec = v; r.err = e; r.ffv = fv; r.ffval = fval;
    r.pass = p; r.busy = bs; r.done = dn; r.lat = lat;
    return r;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input int v, input int er, input int fv,
                     input int fval, input int p, input int bs, input int dn);
    chk({tag, "_vec"}, v, e.vec);
    chk({tag, "_err_count"}, er, e.err);
    chk({tag, "_first_fail_vec"}, fv, e.ffv);
    chk({tag, "_first_fail_valid"}, fval, e.ffval);
    chk({tag, "_pass"}, p, e.pass);
    chk({tag, "_busy"}, bs, e.busy);
    chk({tag, "_done"}, dn, e.done);
  endtask

  // Monitor: vector order/hold, done events of both DUTs, on-demand probes
  bit   busy_prev = 1'b0, done_prev = 1'b0, done_s_prev = 1'b0;
  int   prev_vec = 0, hold = 0, ev_vec = 0, lat = 0;
  exp_t ev;

  always @(negedge clk) begin
    if (busy) begin
      if (!busy_prev || int'({a, b, c, d}) != prev_vec) begin
        if (busy_prev) chk("vec_hold_cycles", hold, 3);
        if (vec_exp_q.size() == 0) begin
          chk("vec_unexpected", int'({a, b, c, d}), -1);
        end else begin
          ev_vec = vec_exp_q.pop_front();
          chk("vec_order", int'({a, b, c, d}), ev_vec);
        end
        hold = 1;
      end else begin
        hold++;
      end
    end
    busy_prev = busy;
    prev_vec  = int'({a, b, c, d});

    if (done && !done_prev) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        ev  = done_q.pop_front();
        lat = int'(($time - 5 - last_start_t) / 10);
        chk("done_latency", lat, ev.lat);
        cmp("done", ev, int'({a, b, c, d}), int'(err), int'(ffv), int'(ffval),
            int'(pass), int'(busy), int'(done));
      end
    end
    done_prev = done;

    if (done_s && !done_s_prev) begin
      if (sof_q.size() == 0) begin
        chk("sof_done_unexpected", 1, 0);
      end else begin
        ev  = sof_q.pop_front();
        lat = int'(($time - 5 - last_start_s_t) / 10);
        chk("sof_latency", lat, ev.lat);
        cmp("sof", ev, int'({a_s, b_s, c_s, d_s}), int'(err_s), int'(ffv_s), int'(ffval_s),
            int'(pass_s), int'(busy_s), int'(done_s));
      end
    end
    done_s_prev = done_s;

    if (probe_req && probe_q.size() != 0) begin
      ev = probe_q.pop_front();
      cmp("probe", ev, int'({a, b, c, d}), int'(err), int'(ffv), int'(ffval),
          int'(pass), int'(busy), int'(done));
    end
  end

  task automatic probe(input exp_t e);
    probe_q.push_back(e);
    probe_req = 1'b1;
    @(posedge clk);
    #1 probe_req = 1'b0;
  endtask

  task automatic do_start(input bit sof);
    @(posedge clk);
    #1;
    if (sof) start_s = 1'b1; else start = 1'b1;
    @(posedge clk);
    if (sof) last_start_s_t = $time; else last_start_t = $time;
    #1;
    start   = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic push_vecs(input int last);
    for (int i = 0; i <= last; i++) vec_exp_q.push_back(i);
  endtask

  task automatic wait_done(input bit sof);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = sof ? done_s : done;
    end
    if (!seen) chk("wait_done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vec(input int v);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = busy && (int'({a, b, c, d}) == v);
    end
    if (!seen) chk("wait_vec_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    probe(mk(0, 0, 0, 0, 0, 0, 0, -1));

    // Golden datapath, plus a start while busy that must be ignored
    fault_mode = 0;
    push_vecs(15);
    done_q.push_back(mk(15, 0, 0, 0, 1, 0, 1, 48));
    do_start(1'b0);
    wait_vec(4);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1'b0);

    // y forced low at vector 9
    fault_mode = 1;
    push_vecs(15);
    done_q.push_back(mk(15, 1, 9, 1, 0, 0, 1, 48));
    do_start(1'b0);
    wait_done(1'b0);

    // y stuck at 1: the nine zero entries mismatch
    fault_mode = 2;
    push_vecs(15);
    done_q.push_back(mk(15, 9, 0, 1, 0, 0, 1, 48));
    do_start(1'b0);
    wait_done(1'b0);

    // start+abort during vector 5 settle: errors from vectors 0,1,3,4 retained
    push_vecs(5);
    do_start(1'b0);
    wait_vec(5);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    probe(mk(0, 4, 0, 1, 0, 0, 0, -1));

    // Restart clears the record
    fault_mode = 0;
    push_vecs(15);
    done_q.push_back(mk(15, 0, 0, 0, 1, 0, 1, 48));
    do_start(1'b0);
    probe(mk(0, 0, 0, 0, 0, 1, 0, -1));
    wait_done(1'b0);

    // Reset for two cycles in the middle of a sweep at vector 6
    fault_mode = 2;
    push_vecs(6);
    do_start(1'b0);
    wait_vec(6);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    probe(mk(0, 0, 0, 0, 0, 0, 0, -1));
    repeat (5) @(posedge clk);
    #1;
    probe(mk(0, 0, 0, 0, 0, 0, 0, -1));

    // Stop-on-fail instance with y stuck at 1 stops at vector 0
    sof_q.push_back(mk(0, 1, 0, 1, 0, 0, 1, 3));
    do_start(1'b1);
    wait_done(1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("done_queue_drained", done_q.size(), 0);
    chk("sof_queue_drained", sof_q.size(), 0);
    chk("vec_queue_drained", vec_exp_q.size(), 0);
    chk("probe_queue_drained", probe_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
